// File: rtl/linebuffer_pkg.sv
// Shared types for the line-buffer sequencer: FSM states and the error code
// reported to the status register block.
package linebuffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_CLR    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_SHORT = 2'd1,
    ERR_LONG  = 2'd2,
    ERR_SOF   = 2'd3
  } err_e;

endpackage

// File: rtl/linebuffer_seq_if.sv
// Pixel-in, pair-out and line-buffer side signals of the sequencer.
// master = sequencer side, slave = video source / buffer / filter side.
interface linebuffer_seq_if #(parameter int DATA_WIDTH = 16);
  logic                  s_valid, s_ready, s_sof, s_eol;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  lb_in_valid, lb_clr;
  logic [DATA_WIDTH-1:0] lb_data_in, lb_data_out;
  logic                  m_valid, m_ready, m_sof, m_eol, m_eof;
  logic [DATA_WIDTH-1:0] m_data_cur, m_data_prev;
  logic                  err_short, err_long, err_sof, frame_done;

  modport master (
    input  s_valid, s_data, s_sof, s_eol, lb_data_out, m_ready,
    output s_ready, lb_in_valid, lb_data_in, lb_clr,
           m_valid, m_data_cur, m_data_prev, m_sof, m_eol, m_eof,
           err_short, err_long, err_sof, frame_done
  );

  modport slave (
    output s_valid, s_data, s_sof, s_eol, lb_data_out, m_ready,
    input  s_ready, lb_in_valid, lb_data_in, lb_clr,
           m_valid, m_data_cur, m_data_prev, m_sof, m_eol, m_eof,
           err_short, err_long, err_sof, frame_done
  );
endinterface

// File: rtl/pix_pos_cnt.sv
// Column/row position of the next pixel to be written; wraps at end of line
// and end of frame, clear has priority over increment.
module pix_pos_cnt #(
  parameter int ADDR_WIDTH = 11,
  parameter int ROW_WIDTH  = 11,
  parameter int LENGTH     = 1920,
  parameter int LINES      = 1080
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_i,
  input  logic                  clr_i,
  output logic [ADDR_WIDTH-1:0] col_o,
  output logic [ROW_WIDTH-1:0]  row_o,
  output logic                  last_col_o,
  output logic                  last_row_o,
  output logic                  at_origin_o
);
  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic [ROW_WIDTH-1:0]  row_q, row_d;

  assign col_o       = col_q;
  assign row_o       = row_q;
  assign last_col_o  = (col_q == ADDR_WIDTH'(LENGTH - 1));
  assign last_row_o  = (row_q == ROW_WIDTH'(LINES - 1));
  assign at_origin_o = (col_q == '0) && (row_q == '0);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (inc_i) begin
      if (last_col_o) begin
        col_d = '0;
        row_d = last_row_o ? '0 : row_q + ROW_WIDTH'(1);
      end else begin
        col_d = col_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end
endmodule

// File: rtl/linebuffer_seq.sv
// Frame sequencer for a two-line ping-pong buffer: tracks raster position,
// writes pixels, emits (cur, prev) pairs from row 1 on, resyncs on framing errors.
module linebuffer_seq #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16,
  parameter int LENGTH     = 1920,
  parameter int ROW_WIDTH  = 11,
  parameter int LINES      = 1080
) (
  input  logic             clk,
  input  logic             rst_n,
  linebuffer_seq_if.master bus
);
  import linebuffer_pkg::*;

  state_e                state_q, state_d;
  err_e                  err_q, err_d;
  logic                  fd_q, fd_d;
  logic                  mv_q, mv_d, msof_q, msof_d, meol_q, meol_d, meof_q, meof_d;
  logic [DATA_WIDTH-1:0] cur_q, cur_d, prev_q, prev_d;

  logic [ADDR_WIDTH-1:0] col;
  logic [ROW_WIDTH-1:0]  row;
  logic                  last_col, last_row, at_origin;
  logic                  active, take, sof_err, s_ready, accept;
  logic                  short_err, long_err, wr, emit, cnt_clr;

  pix_pos_cnt #(
    .ADDR_WIDTH(ADDR_WIDTH), .ROW_WIDTH(ROW_WIDTH), .LENGTH(LENGTH), .LINES(LINES)
  ) u_pos (
    .clk(clk), .rst_n(rst_n), .inc_i(wr), .clr_i(cnt_clr),
    .col_o(col), .row_o(row), .last_col_o(last_col), .last_row_o(last_row),
    .at_origin_o(at_origin)
  );

  // A stray sof is only flagged when the pixel could otherwise have been taken,
  // so a stalled output stage never turns into a spurious resync.
  always_comb begin
    active    = (state_q == ST_FILL) || (state_q == ST_STREAM);
    take      = (state_q == ST_STREAM) ? (!mv_q || bus.m_ready) : (state_q != ST_CLR);
    sof_err   = active && take && bus.s_valid && bus.s_sof && !at_origin;
    s_ready   = rst_n && take && !sof_err;
    accept    = bus.s_valid && s_ready;
    short_err = accept && active && bus.s_eol && !last_col;
    long_err  = accept && active && !bus.s_eol && last_col;
    wr        = accept && (active ? !(short_err || long_err) : bus.s_sof);
    emit      = wr && (state_q == ST_STREAM);
  end

  always_comb begin
    state_d = state_q;
    err_d   = ERR_NONE;
    fd_d    = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: if (wr) state_d = ST_FILL;
      ST_FILL, ST_STREAM: begin
        if (sof_err) begin
          state_d = ST_CLR;
          err_d   = ERR_SOF;
        end else if (short_err) begin
          state_d = ST_CLR;
          err_d   = ERR_SHORT;
        end else if (long_err) begin
          state_d = ST_CLR;
          err_d   = ERR_LONG;
        end else if (wr && last_col) begin
          if (state_q == ST_FILL) begin
            state_d = ST_STREAM;
          end else if (last_row) begin
            state_d = ST_CLR;
            fd_d    = 1'b1;
          end
        end
        cnt_clr = (state_d == ST_CLR);
      end
      ST_CLR: begin
        state_d = (err_q == ERR_SOF) ? ST_FILL : ST_IDLE;
        cnt_clr = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mv_d   = mv_q;
    cur_d  = cur_q;
    prev_d = prev_q;
    msof_d = msof_q;
    meol_d = meol_q;
    meof_d = meof_q;
    if (emit) begin
      mv_d   = 1'b1;
      cur_d  = bus.s_data;
      prev_d = bus.lb_data_out;
      msof_d = (row == ROW_WIDTH'(1)) && (col == '0);
      meol_d = last_col;
      meof_d = last_col && last_row;
    end else if (bus.m_ready) begin
      mv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_NONE;
      fd_q    <= 1'b0;
      mv_q    <= 1'b0;
      cur_q   <= '0;
      prev_q  <= '0;
      msof_q  <= 1'b0;
      meol_q  <= 1'b0;
      meof_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      fd_q    <= fd_d;
      mv_q    <= mv_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
      msof_q  <= msof_d;
      meol_q  <= meol_d;
      meof_q  <= meof_d;
    end
  end

  assign bus.s_ready     = s_ready;
  assign bus.lb_in_valid = wr;
  assign bus.lb_data_in  = bus.s_data;
  assign bus.lb_clr      = !rst_n || (state_q == ST_CLR);
  assign bus.m_valid     = mv_q;
  assign bus.m_data_cur  = cur_q;
  assign bus.m_data_prev = prev_q;
  assign bus.m_sof       = mv_q && msof_q;
  assign bus.m_eol       = mv_q && meol_q;
  assign bus.m_eof       = mv_q && meof_q;
  assign bus.err_short   = (err_q == ERR_SHORT);
  assign bus.err_long    = (err_q == ERR_LONG);
  assign bus.err_sof     = (err_q == ERR_SOF);
  assign bus.frame_done  = fd_q;
endmodule

// File: tb/tb_linebuffer_seq.sv
// Directed bench for linebuffer_seq with a 4x3 frame and a one-line-delay
// buffer model feeding lb_data_out.
module tb_linebuffer_seq;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  linebuffer_seq_if #(.DATA_WIDTH(DW)) bus ();

  linebuffer_seq #(
    .ADDR_WIDTH(2), .DATA_WIDTH(DW), .LENGTH(4), .ROW_WIDTH(2), .LINES(3)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Line memory: read old pixel at the write address, then overwrite it.
  logic [DW-1:0] mem [4];
  logic [1:0]    waddr;
  assign bus.lb_data_out = mem[waddr];
  always @(posedge clk) begin
    if (bus.lb_clr) waddr <= 2'd0;
    else if (bus.lb_in_valid) begin
      mem[waddr] <= bus.lb_data_in;
      waddr      <= waddr + 2'd1;
    end
  end

  typedef struct {
    logic v, sof, eol, mr;
    logic [DW-1:0] d;
    logic e_rdy, e_wr, e_clr, e_mv, e_fd;
    logic [DW-1:0] e_cur, e_prev;
    logic [2:0] e_fl;
    logic [2:0] e_err;
  } vec_t;

  vec_t q[$];

  task automatic chk(input string nm, input string f, input int i,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s[%0d] got=%0h want=%0h", nm, f, i, act, exp);
    end
  endtask

  // ctl={valid,sof,eol}, cmb={s_ready,lb_in_valid,lb_clr}, fl={m_sof,m_eol,m_eof},
  // err={short,long,sof}
  task automatic add(input logic [2:0] ctl, input int d, input logic mr,
                     input logic [2:0] cmb, input logic mv, input int cur, input int prev,
                     input logic [2:0] fl, input logic [2:0] err, input logic fd);
    vec_t t;
    t.v = ctl[2]; t.sof = ctl[1]; t.eol = ctl[0]; t.d = DW'(d); t.mr = mr;
    t.e_rdy = cmb[2]; t.e_wr = cmb[1]; t.e_clr = cmb[0];
    t.e_mv = mv; t.e_cur = DW'(cur); t.e_prev = DW'(prev);
    t.e_fl = fl; t.e_err = err; t.e_fd = fd;
    q.push_back(t);
  endtask

  task automatic run_q(input string nm);
    for (int i = 0; i < q.size(); i++) begin
      vec_t t = q[i];
      @(negedge clk);
      bus.s_valid = t.v; bus.s_sof = t.sof; bus.s_eol = t.eol;
      bus.s_data = t.d; bus.m_ready = t.mr;
      #1;
      chk(nm, "s_ready", i, bus.s_ready, t.e_rdy);
      chk(nm, "lb_wr", i, bus.lb_in_valid, t.e_wr);
      chk(nm, "lb_clr", i, bus.lb_clr, t.e_clr);
      if (t.e_wr) chk(nm, "lb_din", i, bus.lb_data_in, t.d);
      @(posedge clk);
      #1;
      chk(nm, "m_valid", i, bus.m_valid, t.e_mv);
      chk(nm, "flags", i, {bus.m_sof, bus.m_eol, bus.m_eof}, t.e_fl);
      chk(nm, "err", i, {bus.err_short, bus.err_long, bus.err_sof}, t.e_err);
      chk(nm, "frame_done", i, bus.frame_done, t.e_fd);
      if (t.e_mv) begin
        chk(nm, "cur", i, bus.m_data_cur, t.e_cur);
        chk(nm, "prev", i, bus.m_data_prev, t.e_prev);
      end
    end
    q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.s_valid = 1'b0; bus.s_sof = 1'b0; bus.s_eol = 1'b0;
    bus.s_data = '0; bus.m_ready = 1'b0;

    // reset held 3 cycles
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("reset", "outs", c, {bus.m_valid, bus.m_sof, bus.m_eol, bus.m_eof, bus.err_short,
          bus.err_long, bus.err_sof, bus.frame_done, bus.lb_in_valid, bus.s_ready}, 32'h0);
      chk("reset", "lb_clr", c, bus.lb_clr, 1'b1);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    chk("reset", "lb_clr_rel", 0, bus.lb_clr, 1'b0);
    chk("reset", "s_ready_rel", 0, bus.s_ready, 1'b1);

    // nominal frame 0..11
    add(3'b110,  0, 1, 3'b110, 0,  0, 0, 3'b000, 3'b000, 0);
    add(3'b100,  1, 1, 3'b110, 0,  0, 0, 3'b000, 3'b000, 0);
    add(3'b100,  2, 1, 3'b110, 0,  0, 0, 3'b000, 3'b000, 0);
    add(3'b101,  3, 1, 3'b110, 0,  0, 0, 3'b000, 3'b000, 0);
    add(3'b100,  4, 1, 3'b110, 1,  4, 0, 3'b100, 3'b000, 0);
    add(3'b100,  5, 1, 3'b110, 1,  5, 1, 3'b000, 3'b000, 0);
    add(3'b100,  6, 1, 3'b110, 1,  6, 2, 3'b000, 3'b000, 0);
    add(3'b101,  7, 1, 3'b110, 1,  7, 3, 3'b010, 3'b000, 0);
    add(3'b100,  8, 1, 3'b110, 1,  8, 4, 3'b000, 3'b000, 0);
    add(3'b100,  9, 1, 3'b110, 1,  9, 5, 3'b000, 3'b000, 0);
    add(3'b100, 10, 1, 3'b110, 1, 10, 6, 3'b000, 3'b000, 0);
    add(3'b101, 11, 1, 3'b110, 1, 11, 7, 3'b011, 3'b000, 1);
    add(3'b000,  0, 1, 3'b001, 0,  0, 0, 3'b000, 3'b000, 0);
    add(3'b000,  0, 1, 3'b100, 0,  0, 0, 3'b000, 3'b000, 0);
    run_q("nominal");

    // backpressure: m_ready low for 5 cycles in row 1
    add(3'b110, 20, 1, 3'b110, 0,  0,  0, 3'b000, 3'b000, 0);
    add(3'b100, 21, 1, 3'b110, 0,  0,  0, 3'b000, 3'b000, 0);
    add(3'b100, 22, 1, 3'b110, 0,  0,  0, 3'b000, 3'b000, 0);
    add(3'b101, 23, 1, 3'b110, 0,  0,  0, 3'b000, 3'b000, 0);
    add(3'b100, 24, 1, 3'b110, 1, 24, 20, 3'b100, 3'b000, 0);
    add(3'b100, 25, 1, 3'b110, 1, 25, 21, 3'b000, 3'b000, 0);
    for (int k = 0; k < 5; k++)
      add(3'b100, 26, 0, 3'b000, 1, 25, 21, 3'b000, 3'b000, 0);
    add(3'b100, 26, 1, 3'b110, 1, 26, 22, 3'b000, 3'b000, 0);
    add(3'b101, 27, 1, 3'b110, 1, 27, 23, 3'b010, 3'b000, 0);
    add(3'b100, 28, 1, 3'b110, 1, 28, 24, 3'b000, 3'b000, 0);
    add(3'b100, 29, 1, 3'b110, 1, 29, 25, 3'b000, 3'b000, 0);
    add(3'b100, 30, 1, 3'b110, 1, 30, 26, 3'b000, 3'b000, 0);
    add(3'b101, 31, 1, 3'b110, 1, 31, 27, 3'b011, 3'b000, 1);
    add(3'b000,  0, 1, 3'b001, 0,  0,  0, 3'b000, 3'b000, 0);
    run_q("backpressure");

    // short line: eol at col 2 of row 1, then non-sof pixels dropped
    add(3'b110, 40, 1, 3'b110, 0,  0,  0, 3'b000, 3'b000, 0);
    add(3'b100, 41, 1, 3'b110, 0,  0,  0, 3'b000, 3'b000, 0);
    add(3'b100, 42, 1, 3'b110, 0,  0,  0, 3'b000, 3'b000, 0);
    add(3'b101, 43, 1, 3'b110, 0,  0,  0, 3'b000, 3'b000, 0);
    add(3'b100, 44, 1, 3'b110, 1, 44, 40, 3'b100, 3'b000, 0);
    add(3'b100, 45, 1, 3'b110, 1, 45, 41, 3'b000, 3'b000, 0);
    add(3'b101, 46, 1, 3'b100, 0,  0,  0, 3'b000, 3'b100, 0);
    add(3'b100, 47, 1, 3'b001, 0,  0,  0, 3'b000, 3'b000, 0);
    add(3'b100, 48, 1, 3'b100, 0,  0,  0, 3'b000, 3'b000, 0);
    add(3'b101, 49, 1, 3'b100, 0,  0,  0, 3'b000, 3'b000, 0);
    run_q("short");

    // long line: no eol at col 3 of row 0
    add(3'b110, 60, 1, 3'b110, 0, 0, 0, 3'b000, 3'b000, 0);
    add(3'b100, 61, 1, 3'b110, 0, 0, 0, 3'b000, 3'b000, 0);
    add(3'b100, 62, 1, 3'b110, 0, 0, 0, 3'b000, 3'b000, 0);
    add(3'b100, 63, 1, 3'b100, 0, 0, 0, 3'b000, 3'b010, 0);
    add(3'b000,  0, 1, 3'b001, 0, 0, 0, 3'b000, 3'b000, 0);
    add(3'b000,  0, 1, 3'b100, 0, 0, 0, 3'b000, 3'b000, 0);
    run_q("long");

    // mid-frame sof at (1,1): held, CLR, then restarts as (0,0)
    add(3'b110, 80, 1, 3'b110, 0,  0,  0, 3'b000, 3'b000, 0);
    add(3'b100, 81, 1, 3'b110, 0,  0,  0, 3'b000, 3'b000, 0);
    add(3'b100, 82, 1, 3'b110, 0,  0,  0, 3'b000, 3'b000, 0);
    add(3'b101, 83, 1, 3'b110, 0,  0,  0, 3'b000, 3'b000, 0);
    add(3'b100, 84, 1, 3'b110, 1, 84, 80, 3'b100, 3'b000, 0);
    add(3'b110, 85, 1, 3'b000, 0,  0,  0, 3'b000, 3'b001, 0);
    add(3'b110, 85, 1, 3'b001, 0,  0,  0, 3'b000, 3'b000, 0);
    add(3'b110, 85, 1, 3'b110, 0,  0,  0, 3'b000, 3'b000, 0);
    add(3'b100, 86, 1, 3'b110, 0,  0,  0, 3'b000, 3'b000, 0);
    add(3'b100, 87, 1, 3'b110, 0,  0,  0, 3'b000, 3'b000, 0);
    add(3'b101, 88, 1, 3'b110, 0,  0,  0, 3'b000, 3'b000, 0);
    add(3'b100, 89, 1, 3'b110, 1, 89, 85, 3'b100, 3'b000, 0);
    add(3'b100, 90, 1, 3'b110, 1, 90, 86, 3'b000, 3'b000, 0);
    run_q("midsof");

    // reset mid-frame with a pending pair: nothing drained
    @(negedge clk);
    rst_n = 1'b0; bus.s_valid = 1'b0; bus.m_ready = 1'b0;
    #1;
    chk("midrst", "lb_clr", 0, bus.lb_clr, 1'b1);
    chk("midrst", "s_ready", 0, bus.s_ready, 1'b0);
    @(posedge clk); #1;
    chk("midrst", "m_valid", 0, bus.m_valid, 1'b0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("midrst", "s_ready", 1, bus.s_ready, 1'b1);
    chk("midrst", "lb_clr", 1, bus.lb_clr, 1'b0);
    @(posedge clk); #1;
    chk("midrst", "m_valid", 1, bus.m_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
